// File: rtl/md_issue_ctrl.sv
// Issue-side controller for the HI/LO multiply/divide unit: moves the D-stage
// instruction into E, raises a one-cycle start, tracks latency, stalls HI/LO hazards.
module md_issue_ctrl #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr_d,
   input  logic        flush_e,
   input  logic        md_busy,
   output logic [31:0] instr_e,
   output logic        md_start,
   output logic        stall_d,
   output logic        md_pending,
   output logic [15:0] stall_cnt
);

   typedef enum logic {
      PH_IDLE,
      PH_RUN
   } phase_e;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [3:0] FN_MD      = 4'b0110;  // funct 0110xx: MULT/MULTU/DIV/DIVU
   localparam logic [3:0] FN_MOVE    = 4'b0100;  // funct 0100xx: MFHI/MTHI/MFLO/MTLO

   logic [31:0] instr_e_q, instr_e_d;
   logic [3:0]  cnt_q, cnt_d;
   phase_e      phase_q, phase_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   logic d_special, d_is_hilo;
   logic e_special, e_is_md, e_is_div;

   assign d_special = (instr_d[31:26] == OP_SPECIAL);
   assign d_is_hilo = d_special && ((instr_d[5:2] == FN_MD) || (instr_d[5:2] == FN_MOVE));
   assign e_special = (instr_e_q[31:26] == OP_SPECIAL);
   assign e_is_md   = e_special && (instr_e_q[5:2] == FN_MD);
   assign e_is_div  = instr_e_q[1];

   // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      md_start    = e_is_md;
      md_pending  = 1'b0;
      stall_d     = 1'b0;
      instr_e_d   = instr_d;
      cnt_d       = cnt_q;
      phase_d     = phase_q;
      stall_cnt_d = stall_cnt_q;

      md_pending = md_start || (cnt_q != 4'd0) || md_busy;
      stall_d    = d_is_hilo && md_pending;

      if (flush_e || stall_d) begin
         instr_e_d = 32'd0;
      end

      if (md_start) begin
         cnt_d = e_is_div ? 4'(DIV_LAT) : 4'(MULT_LAT);
      end else if (cnt_q != 4'd0) begin
         cnt_d = cnt_q - 4'd1;
      end

      // START is the cycle md_start is high; md_busy keeps RUN alive past cnt.
      case (phase_q)
         PH_IDLE: if (md_start) phase_d = PH_RUN;
         PH_RUN:  if (!md_start && cnt_q == 4'd0 && !md_busy) phase_d = PH_IDLE;
         default: phase_d = PH_IDLE;
      endcase

      if (stall_d && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr_e_q   <= 32'd0;
         cnt_q       <= 4'd0;
         phase_q     <= PH_IDLE;
         stall_cnt_q <= 16'd0;
      end else begin
         instr_e_q   <= instr_e_d;
         cnt_q       <= cnt_d;
         phase_q     <= phase_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign instr_e   = instr_e_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Issue-side controller for the HI/LO multiply/divide unit. It sits between the decode (D) and execute (E) pipeline registers. It forwards the D-stage instruction into E, raises a one-cycle start request when a MULT/MULTU/DIV/DIVU reaches E, and tracks the operation's latency. It stalls D while any HI/LO-touching instruction would otherwise overtake a running operation.

## Interface
Parameters:
- MULT_LAT, 5, extra busy cycles after start for MULT/MULTU (1..15)
- DIV_LAT, 10, extra busy cycles after start for DIV/DIVU (1..15)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- instr_d  in  32  D-stage instruction word
- flush_e  in  1  insert a bubble into E this cycle (branch/exception)
- md_busy  in  1  busy report from the multiply/divide unit
- instr_e  out  32  registered E-stage instruction, drives the unit's Instr2
- md_start  out  1  start request to the unit
- stall_d  out  1  freeze PC and the D register (combinational)
- md_pending  out  1  operation in flight
- stall_cnt  out  16  saturating count of cycles with stall_d=1

## Operation
- Decode applies to SPECIAL (op=000000) only.
  - MD ops: funct 011000, 011001, 011010, 011011.
  - HI/LO ops: MD ops plus MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
- Latency counter cnt is 4 bits.
  - On any cycle with md_start=1, cnt loads MULT_LAT for funct 0110x0x… (MULT/MULTU) or DIV_LAT for DIV/DIVU.
  - Otherwise cnt decrements by 1 while cnt≠0.
- md_pending = md_start | (cnt≠0) | md_busy.
- stall_d = (instr_d is a HI/LO op) & md_pending. Non-HI/LO instructions never stall.
- E register update, each rising edge, in priority order:
  - if flush_e, load 0 (NOP);
  - else if stall_d, load 0 (bubble);
  - else load instr_d.
- md_start = (instr_e is an MD op). It is combinational from the E register, so it is exactly one cycle per issued op.
- State machine, with state held in cnt plus a phase bit:
  - IDLE: md_pending=0.
  - START: md_start=1.
  - RUN: cnt≠0 or md_busy=1.
  - Transitions are START→RUN, then RUN→IDLE when cnt=0 and md_busy=0.
  - An MD op in E while RUN cannot occur, because stall_d blocks it.
- md_busy extends RUN beyond cnt; the controller never ends RUN while md_busy=1.
- stall_cnt increments on each stall_d=1 cycle and saturates at 16'hFFFF.
- Reset (reset=0) asynchronously forces:
  - instr_e=0, cnt=0, phase=IDLE, stall_cnt=0;
  - hence md_start=0. stall_d follows md_busy only.
- Reset mid-operation abandons the op; no start is re-issued.
- flush_e does not abort an op already in START or RUN.
- flush_e with an MD op in D: the op never reaches E and no start is issued.

## Timing
- Cycle 0: MULT in D. Cycle 1: MULT in E, md_start=1, md_pending=1.
- Cycles 2..6: cnt=5,4,3,2,1, md_pending=1.
- Cycle 7: cnt=0, md_pending=0 (given md_busy=0).
- A HI/LO op arriving in D at cycle 1 stalls cycles 1–6 (6 cycles) and enters E at cycle 8.
- DIV: same sequence with 10 cnt cycles; a following MFHI stalls 11 cycles.
- Back-to-back MULT, MULT: the second stalls 6 cycles; its start is at cycle 8.
- stall_d has zero latency from instr_d; all other outputs change only on clk or reset.
- Simultaneous flush_e and stall_d: flush wins (E=0). stall_d still holds D.

## Test plan
- Reset: hold reset=0 with random instr_d → instr_e=0, md_start=0, stall_cnt=0, stall_d=0 with md_busy=0.
- MULT then MFLO: instr_d=0x00850018 then 0x00001012 → md_start high in cycle 1 only, MFLO stalled 6 cycles, enters E in cycle 8, stall_cnt=6.
- DIVU then MTHI with md_busy held high to cycle 14 → stall through cycle 14, MTHI in E in cycle 16.
- DIV then ADDU stream: ADDU (0x00851021) never stalls and flows one per cycle during RUN.
- Flush: MULT in D with flush_e=1 → instr_e=0 next cycle, no md_start, md_pending=0.
- Reset asserted in cycle 3 of DIV → cnt=0 and md_pending=0 immediately. After release, a waiting MFHI proceeds without stall.
